// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle input and encoded-word output handshake bundle
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    // Encoder side
    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 field-bundle to instruction-word encoder with one output stage
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP_LD  = 7'b0000011;
    localparam logic [6:0]  OP_ST  = 7'b0100011;
    localparam logic [6:0]  OP_BR  = 7'b1100011;
    localparam logic [6:0]  OP_LUI = 7'b0110111;
    localparam logic [6:0]  OP_JAL = 7'b1101111;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q, err_d;
    logic [31:0]      oaddr_q, oaddr_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

    logic             accept;
    logic             xfer;
    logic [31:0]      enc_instr;
    logic             enc_err;
    logic [31:0]      imm;
    logic signed [31:0] imm_s;

    assign imm          = bus.in_imm;
    assign imm_s        = signed'(bus.in_imm);
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = valid_q && bus.out_ready;

    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_err   = err_q;
    assign bus.out_addr  = oaddr_q;
    assign cnt_ok        = cnt_ok_q;
    assign cnt_err       = cnt_err_q;

    // Encode the presented bundle and flag immediates that cannot be represented
    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        case (bus.in_fmt)
            3'd0, 3'd1: begin
                enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
                enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                             (bus.in_fmt == 3'd0) ? OP_IMM : OP_LD};
            end
            3'd2: begin
                enc_err   = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
                enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], OP_ST};
            end
            3'd3: begin
                enc_err   = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
                enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:1], imm[11], OP_BR};
            end
            3'd4: begin
                enc_err   = (imm[11:0] != 12'd0);
                enc_instr = {imm[31:12], bus.in_rd, OP_LUI};
            end
            3'd5: begin
                enc_err   = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, OP_JAL};
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_instr = NOP;
        end
    end

    // Output stage load/drain, address advance and saturating delivery counters
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        err_d     = err_q;
        oaddr_d   = oaddr_q;
        addr_d    = addr_q;
        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        if (accept) begin
            valid_d = 1'b1;
            instr_d = enc_instr;
            err_d   = enc_err;
            // A word leaving this same cycle has already claimed addr_q
            oaddr_d = xfer ? (addr_q + 32'd4) : addr_q;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        if (xfer) begin
            addr_d = addr_q + 32'd4;
            if (err_q) begin
                if (cnt_err_q != '1) cnt_err_d = cnt_err_q + 1'b1;
            end else begin
                if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any pending word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            instr_q   <= 32'd0;
            err_q     <= 1'b0;
            oaddr_q   <= BASE_ADDR;
            addr_q    <= BASE_ADDR;
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            oaddr_q   <= oaddr_d;
            addr_q    <= addr_d;
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cnt_ok;
    logic [1:0] cnt_err;

    int n_checks = 0;
    int n_errors = 0;

    instr_encoder_if bus ();

    instr_encoder #(.BASE_ADDR(32'h0000_0000), .CNT_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .cnt_ok  (cnt_ok),
        .cnt_err (cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_fmt    = fmt;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_imm    = imm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] exp_addr;
    logic [1:0]  exp_ok;
    logic [1:0]  exp_err;

    initial begin
        vecs[0]  = '{3'd0, 5'd1, 5'd2, 5'd31, 3'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0};
        vecs[1]  = '{3'd2, 5'd9, 5'd4, 5'd3,  3'd2, 32'hFFFF_FFFC, 32'hFE32_2E23, 1'b0};
        vecs[2]  = '{3'd3, 5'd0, 5'd2, 5'd1,  3'd1, 32'hFFFF_FFF8, 32'hFE11_1CE3, 1'b0};
        vecs[3]  = '{3'd3, 5'd0, 5'd0, 5'd0,  3'd0, 32'h0000_0003, 32'h0000_0013, 1'b1};
        vecs[4]  = '{3'd1, 5'd6, 5'd7, 5'd0,  3'd2, 32'h0000_07FF, 32'h7FF3_A303, 1'b0};
        vecs[5]  = '{3'd0, 5'd0, 5'd0, 5'd0,  3'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
        vecs[6]  = '{3'd0, 5'd1, 5'd1, 5'd0,  3'd0, 32'h0000_0800, 32'h0000_0013, 1'b1};
        vecs[7]  = '{3'd3, 5'd0, 5'd0, 5'd0,  3'd0, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
        vecs[8]  = '{3'd3, 5'd0, 5'd0, 5'd0,  3'd0, 32'h0000_1000, 32'h0000_0013, 1'b1};
        vecs[9]  = '{3'd4, 5'd5, 5'd0, 5'd0,  3'd0, 32'h0000_1001, 32'h0000_0013, 1'b1};
        vecs[10] = '{3'd5, 5'd1, 5'd0, 5'd0,  3'd0, 32'h0010_0000, 32'h0000_0013, 1'b1};
        vecs[11] = '{3'd6, 5'd1, 5'd1, 5'd1,  3'd0, 32'h0000_0000, 32'h0000_0013, 1'b1};
        vecs[12] = '{3'd5, 5'd2, 5'd0, 5'd0,  3'd0, 32'hFFFF_FFFE, 32'hFFFF_F16F, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_fmt    = 3'd0;
        bus.in_rd     = 5'd0;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_funct3 = 3'd0;
        bus.in_imm    = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        expect_eq("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        expect_eq("rst out_instr", bus.out_instr, 32'd0);
        expect_eq("rst out_err", {31'd0, bus.out_err}, 32'd0);
        expect_eq("rst out_addr", bus.out_addr, 32'd0);
        expect_eq("rst cnt_ok", {30'd0, cnt_ok}, 32'd0);
        expect_eq("rst cnt_err", {30'd0, cnt_err}, 32'd0);
        do_reset();
        expect_eq("post-rst in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed encodings, one word at a time
        exp_addr = 32'd0;
        exp_ok   = 2'd0;
        exp_err  = 2'd0;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].fmt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].imm);
            tick();
            bus.in_valid = 1'b0;
            expect_eq($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            expect_eq($sformatf("v%0d out_instr", i), bus.out_instr, vecs[i].exp_instr);
            expect_eq($sformatf("v%0d out_err", i), {31'd0, bus.out_err}, {31'd0, vecs[i].exp_err});
            expect_eq($sformatf("v%0d out_addr", i), bus.out_addr, exp_addr);
            tick();
            if (vecs[i].exp_err) begin
                if (exp_err != 2'd3) exp_err = exp_err + 2'd1;
            end else begin
                if (exp_ok != 2'd3) exp_ok = exp_ok + 2'd1;
            end
            exp_addr = exp_addr + 32'd4;
            expect_eq($sformatf("v%0d drained", i), {31'd0, bus.out_valid}, 32'd0);
            expect_eq($sformatf("v%0d cnt_ok", i), {30'd0, cnt_ok}, {30'd0, exp_ok});
            expect_eq($sformatf("v%0d cnt_err", i), {30'd0, cnt_err}, {30'd0, exp_err});
        end

        // LUI then JAL back-to-back
        do_reset();
        drive(3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        tick();
        expect_eq("lui instr", bus.out_instr, 32'h1234_52B7);
        expect_eq("lui addr", bus.out_addr, 32'd0);
        expect_eq("lui in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        tick();
        bus.in_valid = 1'b0;
        expect_eq("jal valid", {31'd0, bus.out_valid}, 32'd1);
        expect_eq("jal instr", bus.out_instr, 32'h0010_00EF);
        expect_eq("jal addr", bus.out_addr, 32'd4);
        tick();
        expect_eq("b2b cnt_ok", {30'd0, cnt_ok}, 32'd2);

        // Backpressure: word pending with out_ready low for 3 cycles
        bus.out_ready = 1'b0;
        drive(3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 32'd5);
        tick();
        drive(3'd1, 5'd6, 5'd7, 5'd0, 3'd2, 32'h0000_07FF);
        for (int k = 0; k < 3; k++) begin
            expect_eq($sformatf("bp%0d in_ready", k), {31'd0, bus.in_ready}, 32'd0);
            expect_eq($sformatf("bp%0d out_valid", k), {31'd0, bus.out_valid}, 32'd1);
            expect_eq($sformatf("bp%0d out_instr", k), bus.out_instr, 32'h0050_0193);
            expect_eq($sformatf("bp%0d out_addr", k), bus.out_addr, 32'd8);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        expect_eq("bp next instr", bus.out_instr, 32'h7FF3_A303);
        expect_eq("bp next addr", bus.out_addr, 32'd12);
        tick();
        expect_eq("bp drained", {31'd0, bus.out_valid}, 32'd0);
        expect_eq("bp cnt_ok sat", {30'd0, cnt_ok}, 32'd3);

        // Reset while a word is pending
        bus.out_ready = 1'b0;
        drive(3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        expect_eq("pre-rst valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        expect_eq("async rst valid", {31'd0, bus.out_valid}, 32'd0);
        expect_eq("async rst cnt_ok", {30'd0, cnt_ok}, 32'd0);
        expect_eq("async rst cnt_err", {30'd0, cnt_err}, 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        expect_eq("rst2 in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
        tick();
        bus.in_valid = 1'b0;
        expect_eq("rst2 addr", bus.out_addr, 32'd0);
        tick();
        expect_eq("rst2 cnt_ok", {30'd0, cnt_ok}, 32'd1);
        expect_eq("rst2 cnt_err", {30'd0, cnt_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: address tagged on the first encoded word after reset.
REQ-002 Parameter CNT_W, default 16: width of the two statistics counters.
REQ-003 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: field bundle present.
REQ-006 Port in_ready, output, 1: the block accepts the bundle this cycle.
REQ-007 Port in_fmt, input, 3: format code. 0=OP-IMM (7'b0010011), 1=LOAD (7'b0000011), 2=STORE (7'b0100011), 3=BRANCH (7'b1100011), 4=LUI (7'b0110111), 5=JAL (7'b1101111), 6-7 illegal.
REQ-008 Ports in_rd, in_rs1, in_rs2, input, 5 each: register fields.
REQ-009 Port in_funct3, input, 3: funct3 field.
REQ-010 Port in_imm, input, 32: byte-offset or immediate value, signed.
REQ-011 Port out_valid, output, 1: encoded word present.
REQ-012 Port out_ready, input, 1: consumer accepts the word.
REQ-013 Port out_instr, output, 32: encoded instruction word.
REQ-014 Port out_addr, output, 32: target address of out_instr.
REQ-015 Port out_err, output, 1: the word was substituted because of an encoding error.
REQ-016 Ports cnt_ok and cnt_err, output, CNT_W each: counts of good words and error words delivered.

Function
REQ-017 The datapath is one output register stage; latency from acceptance to out_valid=1 is exactly 1 cycle.
REQ-018 in_ready shall equal !out_valid || out_ready. A bundle is accepted when in_valid && in_ready.
REQ-019 While out_valid && !out_ready, out_instr, out_addr and out_err shall hold stable.
REQ-020 On acceptance, out_valid becomes 1. Otherwise, on an output transfer (out_valid && out_ready), out_valid becomes 0.
REQ-021 OP-IMM and LOAD encoding: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-022 STORE encoding: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-023 BRANCH encoding: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-024 LUI encoding: {imm[31:12], rd, opcode}.
REQ-025 JAL encoding: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-026 Fields not used by a format shall be ignored, including rs2 for OP-IMM, LOAD, LUI and JAL.
REQ-027 The following are errors:
- OP-IMM, LOAD or STORE with imm outside -2048..2047.
- BRANCH with imm outside -4096..4094, or with imm[0]=1.
- LUI with imm[11:0] not equal to 0.
- JAL with imm outside -1048576..1048574, or with imm[0]=1.
- Illegal in_fmt.
REQ-028 On an error, out_instr shall be 32'h0000_0013 (NOP) and out_err shall be 1. Otherwise out_err shall be 0.
REQ-029 The address counter starts at BASE_ADDR. It advances by 4 on each output transfer and wraps modulo 2^32. out_addr is the counter value captured at acceptance.
REQ-030 On an output transfer, cnt_ok increments when out_err=0 and cnt_err increments when out_err=1. Both saturate at all-ones.
REQ-031 Simultaneous output transfer and new acceptance in the same cycle: the new word loads with no bubble, and the address advances by exactly 4.

Reset
REQ-032 While rst=1, asynchronously:
- out_valid=0
- out_instr=0, out_err=0
- out_addr=BASE_ADDR, address counter=BASE_ADDR
- cnt_ok=0, cnt_err=0
REQ-033 A word held un-transferred when rst asserts shall be discarded and not counted.
REQ-034 in_ready shall be 1 in the first cycle after rst deasserts.

Verification
REQ-035 I-type: fmt=0, rd=1, rs1=2, funct3=0, imm=32'hFFFF_FFFF, out_ready=1. Required next cycle: out_instr=32'hFFF1_0093, out_addr=0, out_err=0, cnt_ok=1.
REQ-036 LUI then JAL, back-to-back, out_ready=1:
- LUI with rd=5, imm=32'h1234_5000. Required: 32'h1234_52B7 at addr 0.
- JAL with rd=1, imm=2048. Required: 32'h0010_00EF at addr 4.
- No idle cycle between the two words.
REQ-037 BRANCH with imm=3. Required: out_instr=32'h0000_0013, out_err=1, cnt_err=1, cnt_ok unchanged.
REQ-038 Backpressure: hold out_ready=0 for 3 cycles with a word pending. Required:
- in_ready=0 for those 3 cycles.
- out_instr and out_addr stable.
- Address counter advances only after out_ready rises.
REQ-039 Assert rst while a word is pending. Required:
- out_valid drops immediately.
- Next accepted word carries out_addr=BASE_ADDR.
- cnt_ok=0 and cnt_err=0.
REQ-040 Saturation: with CNT_W=2, deliver 5 good words. Required: cnt_ok stays at 3.
